// File: rtl/biu_constants_pkg.sv
// Shared LSU/dmem bus constants: access size type
// and byte-enable / alignment helper functions.
package biu_constants_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } biu_size_t;

  function automatic logic [3:0] size2be(
    input biu_size_t  size,
    input logic [1:0] adr
  );
    logic [3:0] be;
    be = '0;
    unique case (1'b1)
      (size == BYTE):  be = 4'b0001 << adr;
      (size == HWORD): be = 4'b0011 << adr;
      (size == WORD):  be = 4'b1111;
      default:         be = '0;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(
    input biu_size_t  size,
    input logic [1:0] adr
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (size == BYTE):  m = 1'b0;
      (size == HWORD): m = adr[0];
      (size == WORD):  m = |adr;
      default:         m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/riscv_dmem_tcm_ram.sv
// Single-port synchronous RAM, 4-lane byte write mask, no reset.
// Ports: clk, addr, wdata, be, we in; rdata registered out.
module riscv_dmem_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  input  logic          we,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/riscv_dmem_tcm.sv
// Tightly-coupled data memory responder on the dmem_* bus.
// Ports: clk, rst, dmem_req/adr/d/we/size in; dmem_ack/q/misaligned/page_fault out.
module riscv_dmem_tcm
  import biu_constants_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter int               DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0]  BASE_ADDR   = '0,
  parameter int               WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  logic            dmem_we,
  input  biu_size_t       dmem_size,
  output logic            dmem_ack,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW+1:0]   adr_l;
  logic [XLEN-1:0] d_l;
  logic            we_l;
  biu_size_t       size_l;
  logic            mis_l;
  logic            pf_l;

  logic            in_range;
  logic [AW-1:0]   ram_addr;
  logic            ram_we;
  logic [XLEN-1:0] ram_q;

  // BASE_ADDR is aligned to the RAM size, so range is an upper-bit match
  assign in_range = dmem_adr[XLEN-1:AW+2] == BASE_ADDR[XLEN-1:AW+2];

  // In IDLE the RAM reads the live address so zero-wait reads
  // have data ready by RESP
  assign ram_addr = (state == IDLE) ? dmem_adr[AW+1:2]
                                    : adr_l[AW+1:2];

  assign ram_we = (state == RESP) && we_l
                  && !mis_l && !pf_l && !rst;

  riscv_dmem_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .wdata (d_l),
    .be    (size2be(size_l, adr_l[1:0])),
    .we    (ram_we),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      dmem_ack        <= 1'b0;
      dmem_q          <= '0;
      dmem_misaligned <= 1'b0;
      dmem_page_fault <= 1'b0;
    end else begin
      dmem_ack        <= 1'b0;
      dmem_misaligned <= 1'b0;
      dmem_page_fault <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dmem_req) begin
            adr_l  <= dmem_adr[AW+1:0];
            d_l    <= dmem_d;
            we_l   <= dmem_we;
            size_l <= dmem_size;
            mis_l  <= is_misaligned(dmem_size, dmem_adr[1:0]);
            pf_l   <= !in_range;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          dmem_ack        <= 1'b1;
          dmem_misaligned <= mis_l;
          dmem_page_fault <= pf_l && !mis_l;
          if (!we_l) dmem_q <= (mis_l || pf_l) ? '0 : ram_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
